// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared definitions for the ULPI link.
//   - link_state_t : register-access state machine encoding
//   - TX CMD prefixes for register write / register read
//   - RX CMD field offsets and RxEvent codes
package ulpi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CMD  = 3'd1,
    WR_DATA = 3'd2,
    WR_STP  = 3'd3,
    RD_CMD  = 3'd4,
    RD_TURN = 3'd5,
    RD_DATA = 3'd6
  } link_state_t;

  // TX CMD byte = {prefix, 6-bit immediate address}
  localparam logic [1:0] TXCMD_REGWR = 2'b10;
  localparam logic [1:0] TXCMD_REGRD = 2'b11;

  // RX CMD byte layout
  localparam int RXCMD_LINE_LSB = 0;  // [1:0] LineState
  localparam int RXCMD_VBUS_LSB = 2;  // [3:2] VbusState
  localparam int RXCMD_EVT_LSB  = 4;  // [5:4] RxEvent

  // RxEvent codes (bit 0 of the event field is RxActive)
  localparam logic [1:0] RXEVT_NONE    = 2'b00;
  localparam logic [1:0] RXEVT_ACTIVE  = 2'b01;
  localparam logic [1:0] RXEVT_DISCON  = 2'b10;
  localparam logic [1:0] RXEVT_ERROR   = 2'b11;

  // Build a TX CMD byte from a prefix and an immediate address.
  function automatic logic [7:0] txcmd(input logic [1:0] prefix, input logic [5:0] addr);
    return {prefix, addr};
  endfunction

endpackage

// File: rtl/ulpi_link.sv
// ulpi_link: ULPI link-side controller.
//   Register access (immediate address) toward the PHY plus RX CMD / USB
//   receive-data decode from the PHY. All outputs are registered.
//
// Configuration macro: ULPI_LINK_REG_READ_EN
//   defined   : register reads issue a read TX CMD, wait for the PHY to turn
//               the bus, capture the byte, and abort after RD_TIMEOUT cycles.
//   undefined : read states and the timeout counter are not built; a read
//               request completes one cycle after acceptance with reg_err=1.
//
// Ports:
//   ulpi_clk, ulpi_rst          : 60 MHz PHY clock, async active-high reset
//   ulpi_dir, ulpi_nxt          : PHY bus direction and throttle
//   ulpi_data_in/ulpi_data_out  : bus data from / to the PHY
//   ulpi_stp                    : stop strobe to the PHY
//   reg_req/we/addr/wdata       : register access request
//   reg_busy/done/err/rdata     : register access status and result
//   line_state, vbus_state      : last RX CMD fields
//   rx_active, rx_error         : receive packet status
//   rx_data, rx_valid, rx_end   : received byte stream and end-of-packet
module ulpi_link
  import ulpi_pkg::*;
#(
  parameter int RD_TIMEOUT = 32
) (
  input  logic       ulpi_clk,
  input  logic       ulpi_rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic       ulpi_stp,
  output logic [7:0] ulpi_data_out,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_busy,
  output logic       reg_done,
  output logic       reg_err,
  output logic [7:0] reg_rdata,
  output logic [1:0] line_state,
  output logic [1:0] vbus_state,
  output logic       rx_active,
  output logic       rx_error,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_end
);

  if (RD_TIMEOUT < 1) begin : g_bad_rd_timeout
    $error("ulpi_link: RD_TIMEOUT must be at least 1");
  end

  link_state_t state;
  logic        dir_q;     // ulpi_dir from the previous cycle
  logic        tx_on;     // ulpi_data_out currently carries the phase byte
  logic [5:0]  tx_addr;
  logic [7:0]  tx_wdata;
  logic        rx_block;  // the bus byte belongs to a register read, not RX

`ifdef ULPI_LINK_REG_READ_EN
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  logic [CNT_W-1:0] rd_cnt;
`endif

  // Previous-cycle direction, used to spot turnaround cycles.
  always_ff @(posedge ulpi_clk or posedge ulpi_rst) begin
    if (ulpi_rst) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= ulpi_dir;
    end
  end

  // While a read is waiting for its data byte, the PHY byte is not an RX CMD.
  always_comb begin
    rx_block = 1'b0;
`ifdef ULPI_LINK_REG_READ_EN
    if (state == RD_DATA) begin
      rx_block = 1'b1;
    end else begin
      rx_block = 1'b0;
    end
`endif
  end

  // Register-access state machine with registered bus and status outputs.
  always_ff @(posedge ulpi_clk or posedge ulpi_rst) begin
    if (ulpi_rst) begin
      state         <= IDLE;
      ulpi_stp      <= 1'b0;
      ulpi_data_out <= 8'h00;
      reg_busy      <= 1'b0;
      reg_done      <= 1'b0;
      reg_err       <= 1'b0;
      reg_rdata     <= 8'h00;
      tx_on         <= 1'b0;
      tx_addr       <= 6'h00;
      tx_wdata      <= 8'h00;
`ifdef ULPI_LINK_REG_READ_EN
      rd_cnt        <= '0;
`endif
    end else begin
      ulpi_stp <= 1'b0;
      reg_done <= 1'b0;
      reg_err  <= 1'b0;
      case (state)
        IDLE: begin
          // reg_busy stays high through the reg_done cycle, drops here.
          reg_busy      <= 1'b0;
          ulpi_data_out <= 8'h00;
          tx_on         <= 1'b0;
          // A same-cycle dir rise wins: the bus goes to RX.
          if (reg_req && !reg_busy && !ulpi_dir) begin
            reg_busy <= 1'b1;
            tx_addr  <= reg_addr;
            tx_wdata <= reg_wdata;
            if (reg_we) begin
              state         <= WR_CMD;
              ulpi_data_out <= txcmd(TXCMD_REGWR, reg_addr);
              tx_on         <= 1'b1;
            end else begin
`ifdef ULPI_LINK_REG_READ_EN
              state         <= RD_CMD;
              ulpi_data_out <= txcmd(TXCMD_REGRD, reg_addr);
              tx_on         <= 1'b1;
              rd_cnt        <= '0;
`else
              reg_done  <= 1'b1;
              reg_err   <= 1'b1;
              reg_rdata <= 8'h00;
`endif
            end
          end
        end

        WR_CMD: begin
          if (ulpi_dir || dir_q) begin
            // PHY owns the bus or we are in the turnaround after it left.
            ulpi_data_out <= 8'h00;
            tx_on         <= 1'b0;
          end else if (!tx_on) begin
            ulpi_data_out <= txcmd(TXCMD_REGWR, tx_addr);
            tx_on         <= 1'b1;
          end else if (ulpi_nxt) begin
            state         <= WR_DATA;
            ulpi_data_out <= tx_wdata;
          end else begin
            ulpi_data_out <= txcmd(TXCMD_REGWR, tx_addr);
          end
        end

        WR_DATA: begin
          if (ulpi_dir) begin
            // Aborted: the whole write restarts from the TX CMD.
            state         <= WR_CMD;
            ulpi_data_out <= 8'h00;
            tx_on         <= 1'b0;
          end else if (ulpi_nxt) begin
            state         <= WR_STP;
            ulpi_data_out <= 8'h00;
            tx_on         <= 1'b0;
            ulpi_stp      <= 1'b1;
            reg_done      <= 1'b1;
          end else begin
            ulpi_data_out <= tx_wdata;
          end
        end

        WR_STP: begin
          state         <= IDLE;
          ulpi_data_out <= 8'h00;
          reg_busy      <= 1'b0;
        end

`ifdef ULPI_LINK_REG_READ_EN
        RD_CMD, RD_TURN, RD_DATA: begin
          rd_cnt <= rd_cnt + CNT_W'(1);
          if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            state         <= IDLE;
            ulpi_data_out <= 8'h00;
            tx_on         <= 1'b0;
            reg_done      <= 1'b1;
            reg_err       <= 1'b1;
            reg_rdata     <= 8'h00;
          end else if (state == RD_CMD) begin
            if (ulpi_dir || dir_q) begin
              ulpi_data_out <= 8'h00;
              tx_on         <= 1'b0;
            end else if (!tx_on) begin
              ulpi_data_out <= txcmd(TXCMD_REGRD, tx_addr);
              tx_on         <= 1'b1;
            end else if (ulpi_nxt) begin
              state         <= RD_TURN;
              ulpi_data_out <= 8'h00;
              tx_on         <= 1'b0;
            end else begin
              ulpi_data_out <= txcmd(TXCMD_REGRD, tx_addr);
            end
          end else if (state == RD_TURN) begin
            ulpi_data_out <= 8'h00;
            // Leave on the turnaround cycle; the next byte is read data.
            if (ulpi_dir && !dir_q) begin
              state <= RD_DATA;
            end else begin
              state <= RD_TURN;
            end
          end else begin
            ulpi_data_out <= 8'h00;
            if (ulpi_dir) begin
              state     <= IDLE;
              reg_rdata <= ulpi_data_in;
              reg_done  <= 1'b1;
            end else begin
              state <= RD_DATA;
            end
          end
        end
`endif

        default: begin
          state         <= IDLE;
          ulpi_data_out <= 8'h00;
          tx_on         <= 1'b0;
          reg_busy      <= 1'b0;
        end
      endcase
    end
  end

  // RX CMD and receive-data decode, one cycle behind the bus.
  always_ff @(posedge ulpi_clk or posedge ulpi_rst) begin
    if (ulpi_rst) begin
      line_state <= 2'b00;
      vbus_state <= 2'b00;
      rx_active  <= 1'b0;
      rx_error   <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_end     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_end   <= 1'b0;
      // rx_error stays visible alongside rx_end, then clears.
      if (rx_end) begin
        rx_error <= 1'b0;
      end
      if (ulpi_dir && dir_q && !rx_block) begin
        if (ulpi_nxt) begin
          rx_data  <= ulpi_data_in;
          rx_valid <= 1'b1;
        end else begin
          line_state <= ulpi_data_in[RXCMD_LINE_LSB +: 2];
          vbus_state <= ulpi_data_in[RXCMD_VBUS_LSB +: 2];
          rx_active  <= ulpi_data_in[RXCMD_EVT_LSB];
          if (rx_active && !ulpi_data_in[RXCMD_EVT_LSB]) begin
            rx_end <= 1'b1;
          end
          if (ulpi_data_in[RXCMD_EVT_LSB +: 2] == RXEVT_ERROR) begin
            rx_error <= 1'b1;
          end
        end
      end else if (!ulpi_dir && dir_q && rx_active) begin
        // PHY dropped the bus mid-packet.
        rx_active <= 1'b0;
        rx_end    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ulpi_link.sv
// tb_ulpi_link: directed self-checking bench for ulpi_link.
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that produced them.
module tb_ulpi_link;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ulpi_dir = 1'b0;
  logic       ulpi_nxt = 1'b0;
  logic [7:0] ulpi_data_in = 8'h00;
  logic       ulpi_stp;
  logic [7:0] ulpi_data_out;
  logic       reg_req = 1'b0;
  logic       reg_we = 1'b0;
  logic [5:0] reg_addr = 6'h00;
  logic [7:0] reg_wdata = 8'h00;
  logic       reg_busy;
  logic       reg_done;
  logic       reg_err;
  logic [7:0] reg_rdata;
  logic [1:0] line_state;
  logic [1:0] vbus_state;
  logic       rx_active;
  logic       rx_error;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_end;

  int n_vec = 0;
  int n_err = 0;

  ulpi_link #(.RD_TIMEOUT(TMO)) dut (
    .ulpi_clk      (clk),
    .ulpi_rst      (rst),
    .ulpi_dir      (ulpi_dir),
    .ulpi_nxt      (ulpi_nxt),
    .ulpi_data_in  (ulpi_data_in),
    .ulpi_stp      (ulpi_stp),
    .ulpi_data_out (ulpi_data_out),
    .reg_req       (reg_req),
    .reg_we        (reg_we),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_busy      (reg_busy),
    .reg_done      (reg_done),
    .reg_err       (reg_err),
    .reg_rdata     (reg_rdata),
    .line_state    (line_state),
    .vbus_state    (vbus_state),
    .rx_active     (rx_active),
    .rx_error      (rx_error),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_end        (rx_end)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one bus cycle and advance to the next falling edge.
  task automatic cyc(input logic d, input logic n, input logic [7:0] b);
    ulpi_dir     = d;
    ulpi_nxt     = n;
    ulpi_data_in = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic request(input logic we, input logic [5:0] a, input logic [7:0] wd);
    reg_req   = 1'b1;
    reg_we    = we;
    reg_addr  = a;
    reg_wdata = wd;
  endtask

  logic [7:0] rx_bytes [3];

  initial begin
    rx_bytes[0] = 8'hC3;
    rx_bytes[1] = 8'h00;
    rx_bytes[2] = 8'h01;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_data_out", ulpi_data_out, 8'h00);
    check_eq("rst_stp", 8'(ulpi_stp), 8'h00);
    check_eq("rst_busy", 8'(reg_busy), 8'h00);
    check_eq("rst_done", 8'(reg_done), 8'h00);
    check_eq("rst_line", 8'(line_state), 8'h00);
    check_eq("rst_rx_active", 8'(rx_active), 8'h00);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);

    // Register write, nxt on the 3rd cycle of each phase
    request(1'b1, 6'h04, 8'h45);
    cyc(1'b0, 1'b0, 8'h00);
    reg_req = 1'b0;
    check_eq("wr_cmd", ulpi_data_out, 8'h84);
    check_eq("wr_busy", 8'(reg_busy), 8'h01);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("wr_cmd_hold1", ulpi_data_out, 8'h84);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("wr_cmd_hold2", ulpi_data_out, 8'h84);
    cyc(1'b0, 1'b1, 8'h00);
    check_eq("wr_data", ulpi_data_out, 8'h45);
    check_eq("wr_data_done", 8'(reg_done), 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("wr_data_hold1", ulpi_data_out, 8'h45);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("wr_data_hold2", ulpi_data_out, 8'h45);
    cyc(1'b0, 1'b1, 8'h00);
    check_eq("wr_stp", 8'(ulpi_stp), 8'h01);
    check_eq("wr_stp_data", ulpi_data_out, 8'h00);
    check_eq("wr_done", 8'(reg_done), 8'h01);
    check_eq("wr_err", 8'(reg_err), 8'h00);
    check_eq("wr_busy_at_done", 8'(reg_busy), 8'h01);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("wr_stp_end", 8'(ulpi_stp), 8'h00);
    check_eq("wr_done_end", 8'(reg_done), 8'h00);
    check_eq("wr_busy_end", 8'(reg_busy), 8'h00);

    // Register read
    request(1'b0, 6'h0A, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    reg_req = 1'b0;
`ifdef ULPI_LINK_REG_READ_EN
    check_eq("rd_cmd", ulpi_data_out, 8'hCA);
    check_eq("rd_busy", 8'(reg_busy), 8'h01);
    cyc(1'b0, 1'b1, 8'h00);
    check_eq("rd_release", ulpi_data_out, 8'h00);
    cyc(1'b1, 1'b0, 8'hFF);
    check_eq("rd_turn_done", 8'(reg_done), 8'h00);
    cyc(1'b1, 1'b0, 8'h5A);
    check_eq("rd_done", 8'(reg_done), 8'h01);
    check_eq("rd_rdata", reg_rdata, 8'h5A);
    check_eq("rd_err", 8'(reg_err), 8'h00);
    check_eq("rd_not_rxcmd", 8'(line_state), 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("rd_done_end", 8'(reg_done), 8'h00);
    check_eq("rd_busy_end", 8'(reg_busy), 8'h00);
`else
    check_eq("rd_off_done", 8'(reg_done), 8'h01);
    check_eq("rd_off_err", 8'(reg_err), 8'h01);
    check_eq("rd_off_rdata", reg_rdata, 8'h00);
    check_eq("rd_off_bus", ulpi_data_out, 8'h00);
    check_eq("rd_off_busy", 8'(reg_busy), 8'h01);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("rd_off_done_end", 8'(reg_done), 8'h00);
    check_eq("rd_off_busy_end", 8'(reg_busy), 8'h00);
    check_eq("rd_off_bus_end", ulpi_data_out, 8'h00);
`endif

    // RX: RX CMD 0x11, three bytes, RX CMD 0x01
    cyc(1'b1, 1'b0, 8'hFF);
    check_eq("rx_turn_line", 8'(line_state), 8'h00);
    check_eq("rx_turn_active", 8'(rx_active), 8'h00);
    cyc(1'b1, 1'b0, 8'h11);
    check_eq("rx_line", 8'(line_state), 8'h01);
    check_eq("rx_vbus", 8'(vbus_state), 8'h00);
    check_eq("rx_active", 8'(rx_active), 8'h01);
    check_eq("rx_error0", 8'(rx_error), 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, rx_bytes[i]);
      check_eq("rx_valid", 8'(rx_valid), 8'h01);
      check_eq("rx_data", rx_data, rx_bytes[i]);
    end
    cyc(1'b1, 1'b0, 8'h01);
    check_eq("rx_valid_off", 8'(rx_valid), 8'h00);
    check_eq("rx_active_off", 8'(rx_active), 8'h00);
    check_eq("rx_end", 8'(rx_end), 8'h01);
    check_eq("rx_line_hold", 8'(line_state), 8'h01);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("rx_end_once", 8'(rx_end), 8'h00);

    // RX error packet ended by dir falling
    cyc(1'b1, 1'b0, 8'hFF);
    cyc(1'b1, 1'b0, 8'h31);
    check_eq("rxe_active", 8'(rx_active), 8'h01);
    check_eq("rxe_error", 8'(rx_error), 8'h01);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("rxe_end", 8'(rx_end), 8'h01);
    check_eq("rxe_active_off", 8'(rx_active), 8'h00);
    check_eq("rxe_error_hold", 8'(rx_error), 8'h01);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("rxe_end_off", 8'(rx_end), 8'h00);
    check_eq("rxe_error_clr", 8'(rx_error), 8'h00);

    // Write aborted by dir during WR_CMD, then re-issued
    request(1'b1, 6'h16, 8'h3C);
    cyc(1'b0, 1'b0, 8'h00);
    reg_req = 1'b0;
    check_eq("ab_cmd", ulpi_data_out, 8'h96);
    cyc(1'b1, 1'b0, 8'hFF);
    check_eq("ab_release", ulpi_data_out, 8'h00);
    check_eq("ab_done0", 8'(reg_done), 8'h00);
    cyc(1'b1, 1'b0, 8'h0E);
    check_eq("ab_line", 8'(line_state), 8'h02);
    check_eq("ab_vbus", 8'(vbus_state), 8'h03);
    check_eq("ab_bus_idle", ulpi_data_out, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("ab_turn_bus", ulpi_data_out, 8'h00);
    check_eq("ab_busy", 8'(reg_busy), 8'h01);
    check_eq("ab_done1", 8'(reg_done), 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("ab_reissue", ulpi_data_out, 8'h96);
    cyc(1'b0, 1'b1, 8'h00);
    check_eq("ab_data", ulpi_data_out, 8'h3C);
    cyc(1'b0, 1'b1, 8'h00);
    check_eq("ab_stp", 8'(ulpi_stp), 8'h01);
    check_eq("ab_done", 8'(reg_done), 8'h01);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("ab_done_end", 8'(reg_done), 8'h00);
    check_eq("ab_busy_end", 8'(reg_busy), 8'h00);

    // Request in the same cycle as a dir rise is not accepted
    request(1'b1, 6'h01, 8'h00);
    cyc(1'b1, 1'b0, 8'hFF);
    reg_req = 1'b0;
    check_eq("clash_busy", 8'(reg_busy), 8'h00);
    check_eq("clash_bus", ulpi_data_out, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    check_eq("clash_line", 8'(line_state), 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("clash_busy_after", 8'(reg_busy), 8'h00);

`ifdef ULPI_LINK_REG_READ_EN
    // Read where the PHY never turns the bus
    request(1'b0, 6'h0A, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    reg_req = 1'b0;
    cyc(1'b0, 1'b1, 8'h00);
    repeat (TMO - 2) cyc(1'b0, 1'b0, 8'h00);
    check_eq("tmo_early", 8'(reg_done), 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("tmo_done", 8'(reg_done), 8'h01);
    check_eq("tmo_err", 8'(reg_err), 8'h01);
    check_eq("tmo_rdata", reg_rdata, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("tmo_busy_end", 8'(reg_busy), 8'h00);
`endif

    // Reset in the middle of a write drops it silently
    request(1'b1, 6'h04, 8'h45);
    cyc(1'b0, 1'b0, 8'h00);
    reg_req = 1'b0;
    check_eq("mr_busy", 8'(reg_busy), 8'h01);
    rst = 1'b1;
    #1;
    check_eq("mr_busy_rst", 8'(reg_busy), 8'h00);
    check_eq("mr_bus_rst", ulpi_data_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    check_eq("mr_no_done", 8'(reg_done), 8'h00);
    check_eq("mr_no_stp", 8'(ulpi_stp), 8'h00);
    check_eq("mr_bus_idle", ulpi_data_out, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
